// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: access-size encodings,
// FSM state codes, the latched bus request and the request legality check.
package dmem_bridge_pkg;

   // Access size encodings as presented by the core
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // Bridge FSM state codes
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Bus request captured when a legal access leaves IDLE
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [1:0]  off;
   } bus_req_t;

   // A request is legal when it is naturally aligned for its size, uses a
   // defined size code and does not ask for a load and a store at once.
   function automatic logic req_legal(input logic       rd,
                                      input logic       wr,
                                      input logic [1:0] size,
                                      input logic [1:0] off);
      logic aligned;
      case (size)
         SZ_B:    aligned = 1'b1;
         SZ_H:    aligned = ~off[0];
         SZ_W:    aligned = (off == 2'b00);
         default: aligned = 1'b0;
      endcase
      return aligned & ~(rd & wr);
   endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Handshaked memory port: one request channel (valid/ready) carrying address,
// byte enables and write data, plus a read-return channel (rvalid/rdata).
interface dmem_bridge_if;

   logic        valid;
   logic        ready;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;

   // The bridge issues requests
   modport master (
      output valid,
      output we,
      output addr,
      output be,
      output wdata,
      input  ready,
      input  rvalid,
      input  rdata
   );

   // The memory accepts requests and returns read data
   modport slave (
      input  valid,
      input  we,
      input  addr,
      input  be,
      input  wdata,
      output ready,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/dmem_bridge_lane_align.sv
// Byte-lane steering between the core and a 32-bit word-addressed memory.
// Store side: size + address offset -> byte enables and lane-shifted data.
// Load side: returned word shifted down so the addressed byte/half sits at
// bit 0; sign/zero extension is left to the core's load_extend stage.
module dmem_bridge_lane_align
   import dmem_bridge_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  req_off,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   input  logic [1:0]  rd_off,
   input  logic [31:0] rdata,
   output logic [31:0] rdata_aligned
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [2:0] wr_src;
         logic [2:0] rd_src;
         logic       hit_lo;
         logic       hit_hi;

         // Source byte index for this lane; bit 2 flags "outside the word"
         assign wr_src = 3'(gi) - {1'b0, req_off};
         assign rd_src = 3'(gi) + {1'b0, rd_off};

         // Lane is the first or second byte of the access
         assign hit_lo = (2'(gi) == req_off);
         assign hit_hi = (3'(gi) == ({1'b0, req_off} + 3'd1));

         assign be[gi] = (size == SZ_W)
                       | ((size == SZ_B) & hit_lo)
                       | ((size == SZ_H) & (hit_lo | hit_hi));

         assign wdata_lane[8*gi +: 8] =
            wr_src[2] ? 8'h00 : wdata[{wr_src[1:0], 3'b000} +: 8];

         assign rdata_aligned[8*gi +: 8] =
            rd_src[2] ? 8'h00 : rdata[{rd_src[1:0], 3'b000} +: 8];
      end
   endgenerate

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between a single-cycle core and a valid/ready memory
// port. Legal loads/stores are latched and issued on the bus while the core
// is stalled; the stall drops for one DONE cycle in which the core retires.
// Illegal requests never reach the bus and produce a one-cycle cpu_err.
// Accesses that sit in REQ/WAIT for TIMEOUT cycles are aborted with cpu_err.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
   input  logic [1:0]    cpu_size,
   output logic          cpu_stall,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_err,
   dmem_bridge_if.master mem
);

   localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             err_reg;
   logic             err_next;
   logic [31:0]      rdata_reg;
   logic [31:0]      rdata_next;
   bus_req_t         req_reg;
   logic             load_req;

   logic             req_any;
   logic             legal;
   logic             in_access;
   logic             timed_out;
   logic [3:0]       lane_be;
   logic [31:0]      lane_wdata;
   logic [31:0]      lane_rdata;

   assign req_any   = cpu_rd | cpu_wr;
   assign legal     = req_legal(cpu_rd, cpu_wr, cpu_size, cpu_addr[1:0]);
   assign in_access = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
   assign timed_out = in_access && (cnt_reg == CNT_MAX);

   // Store lanes come from the live request (latched on accept); load data is
   // aligned with the offset latched alongside the request.
   dmem_bridge_lane_align u_lane_align (
      .size          (cpu_size),
      .req_off       (cpu_addr[1:0]),
      .wdata         (cpu_wdata),
      .be            (lane_be),
      .wdata_lane    (lane_wdata),
      .rd_off        (req_reg.off),
      .rdata         (mem.rdata),
      .rdata_aligned (lane_rdata)
   );

   // Next-state, read capture and timeout decisions for the access FSM
   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      err_next   = 1'b0;
      rdata_next = rdata_reg;
      load_req   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req_any) begin
               if (legal) begin
                  load_req   = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (timed_out) begin
               err_next   = 1'b1;
               rdata_next = '0;
               state_next = ST_DONE;
            end else if (mem.ready) begin
               if (req_reg.we) begin
                  state_next = ST_DONE;
               end else if (mem.rvalid) begin
                  rdata_next = lane_rdata;
                  state_next = ST_DONE;
               end else begin
                  cnt_next   = cnt_reg + CNT_W'(1);
                  state_next = ST_WAIT;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (timed_out) begin
               err_next   = 1'b1;
               rdata_next = '0;
               state_next = ST_DONE;
            end else if (mem.rvalid) begin
               rdata_next = lane_rdata;
               state_next = ST_DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Core stall: combinational in IDLE so a legal request freezes the core in
   // the cycle it is presented; released only in DONE.
   always_comb begin
      cpu_stall = 1'b0;
      case (state_reg)
         ST_IDLE:         cpu_stall = req_any & legal;
         ST_REQ, ST_WAIT: cpu_stall = 1'b1;
         default:         cpu_stall = 1'b0;
      endcase
   end

   // State, counter, response and latched-request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
         rdata_reg <= '0;
         req_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
         rdata_reg <= rdata_next;
         if (load_req) begin
            req_reg.addr  <= {cpu_addr[31:2], 2'b00};
            req_reg.be    <= lane_be;
            req_reg.wdata <= lane_wdata;
            req_reg.we    <= cpu_wr;
            req_reg.off   <= cpu_addr[1:0];
         end
      end
   end

   // The abort cycle withdraws the request so a late ready cannot be taken
   assign mem.valid = (state_reg == ST_REQ) && !timed_out;
   assign mem.we    = req_reg.we;
   assign mem.addr  = req_reg.addr;
   assign mem.be    = req_reg.be;
   assign mem.wdata = req_reg.wdata;

   assign cpu_rdata = rdata_reg;
   assign cpu_err   = err_reg;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: each access pushes its expected bus request
// and completion onto a scoreboard queue; the access task drives the core and
// memory cycle by cycle and pops/compares when the bridge completes.
module tb_dmem_bridge;
   import dmem_bridge_pkg::*;

   localparam int TIMEOUT = 8;
   localparam int MAX_CYC = 40;

   logic        clk;
   logic        reset;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [1:0]  cpu_size;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        cpu_err;

   int errors = 0;
   int checks = 0;

   dmem_bridge_if mem_bus ();

   dmem_bridge #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_size  (cpu_size),
      .cpu_stall (cpu_stall),
      .cpu_rdata (cpu_rdata),
      .cpu_err   (cpu_err),
      .mem       (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          valid_cyc;
      int          stall_cyc;
      logic        chk_rdata;
      logic [31:0] rdata;
      logic        err_done;
      logic        err_after;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_txn(input string tag, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input int valid_cyc, input int stall_cyc,
                             input logic chk_rdata, input logic [31:0] rdata,
                             input logic err_done, input logic err_after);
      exp_t e;
      e.tag       = tag;
      e.we        = we;
      e.addr      = addr;
      e.be        = be;
      e.wdata     = wdata;
      e.valid_cyc = valid_cyc;
      e.stall_cyc = stall_cyc;
      e.chk_rdata = chk_rdata;
      e.rdata     = rdata;
      e.err_done  = err_done;
      e.err_after = err_after;
      exp_q.push_back(e);
   endtask

   // Called just after a rising edge with the bridge idle. ready_cyc: first
   // cycle (0 = request cycle) ready is held high, -1 = never. rvalid_cyc:
   // the single cycle rvalid pulses, -1 = never.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input int ready_cyc, input int rvalid_cyc, input logic [31:0] resp);
      exp_t        e;
      int          cyc;
      int          stall_n;
      int          valid_n;
      bit          done;
      logic        err_done;
      logic        err_after;
      logic [31:0] rdata_seen;
      e          = exp_q[0];
      cpu_rd     = rd;
      cpu_wr     = wr;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      cpu_size   = size;
      cyc        = 0;
      stall_n    = 0;
      valid_n    = 0;
      done       = 1'b0;
      err_done   = 1'b0;
      rdata_seen = '0;
      while (!done && cyc < MAX_CYC) begin
         mem_bus.ready  = (ready_cyc >= 0) && (cyc >= ready_cyc);
         mem_bus.rvalid = (cyc == rvalid_cyc);
         mem_bus.rdata  = resp;
         @(negedge clk);
         if (mem_bus.valid === 1'b1) begin
            valid_n++;
            check({e.tag, ".we"},    32'(mem_bus.we), 32'(e.we));
            check({e.tag, ".addr"},  mem_bus.addr,    e.addr);
            check({e.tag, ".be"},    32'(mem_bus.be), 32'(e.be));
            check({e.tag, ".wdata"}, mem_bus.wdata,   e.wdata);
         end
         if (cpu_stall === 1'b1) begin
            stall_n++;
         end else begin
            done       = 1'b1;
            err_done   = cpu_err;
            rdata_seen = cpu_rdata;
            check({e.tag, ".err_done"}, 32'(cpu_err), 32'(e.err_done));
            if (e.chk_rdata)
               check({e.tag, ".rdata"}, cpu_rdata, e.rdata);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check({e.tag, ".completed"}, 32'(done), 32'd1);
      check({e.tag, ".stall_cyc"}, 32'(stall_n), 32'(e.stall_cyc));
      check({e.tag, ".valid_cyc"}, 32'(valid_n), 32'(e.valid_cyc));
      cpu_rd         = 1'b0;
      cpu_wr         = 1'b0;
      mem_bus.ready  = 1'b0;
      mem_bus.rvalid = 1'b0;
      @(negedge clk);
      err_after = cpu_err;
      check({e.tag, ".err_after"},   32'(cpu_err),       32'(e.err_after));
      check({e.tag, ".stall_after"}, 32'(cpu_stall),     32'd0);
      check({e.tag, ".valid_after"}, 32'(mem_bus.valid), 32'd0);
      $display("txn %-9s stall=%0d valid=%0d rdata=%08h err=%0b/%0b",
               e.tag, stall_n, valid_n, rdata_seen, err_done, err_after);
      void'(exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      cpu_rd         = 1'b0;
      cpu_wr         = 1'b0;
      cpu_addr       = '0;
      cpu_wdata      = '0;
      cpu_size       = SZ_W;
      mem_bus.ready  = 1'b0;
      mem_bus.rvalid = 1'b0;
      mem_bus.rdata  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.valid", 32'(mem_bus.valid), 32'd0);
      check("rst.we",    32'(mem_bus.we),    32'd0);
      check("rst.be",    32'(mem_bus.be),    32'd0);
      check("rst.err",   32'(cpu_err),       32'd0);
      check("rst.rdata", cpu_rdata,          32'd0);
      check("rst.stall", 32'(cpu_stall),     32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Word store, ready on first REQ cycle
      expect_txn("sw_w", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, SZ_W, 1, -1, 32'h0);

      // Byte store to the top lane
      expect_txn("sb_b3", 1'b1, 32'h10, 4'b1000, 32'hAB000000, 1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
      access(1'b0, 1'b1, 32'h13, 32'h000000AB, SZ_B, 1, -1, 32'h0);

      // Half load from upper half, data returns two cycles after acceptance
      expect_txn("lh_wait", 1'b0, 32'h20, 4'b1100, 32'h0, 1, 4, 1'b1, 32'h00001234, 1'b0, 1'b0);
      access(1'b1, 1'b0, 32'h22, 32'h0, SZ_H, 1, 3, 32'h1234ABCD);

      // Illegal requests: no bus access, no stall, error one cycle later
      expect_txn("lw_misal", 1'b0, 32'h0, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b1);
      access(1'b1, 1'b0, 32'h21, 32'h0, SZ_W, 1, -1, 32'h0);
      expect_txn("lh_misal", 1'b0, 32'h0, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b1);
      access(1'b1, 1'b0, 32'h31, 32'h0, SZ_H, 1, -1, 32'h0);
      expect_txn("size11", 1'b0, 32'h0, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b1);
      access(1'b1, 1'b0, 32'h30, 32'h0, 2'b11, 1, -1, 32'h0);
      expect_txn("rd_and_wr", 1'b0, 32'h0, 4'b0000, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b1);
      access(1'b1, 1'b1, 32'h30, 32'h55, SZ_W, 1, -1, 32'h0);

      // Memory never accepts: TIMEOUT valid cycles, abort cycle, DONE with error
      expect_txn("lw_tmo", 1'b0, 32'h40, 4'b1111, 32'h0, TIMEOUT, TIMEOUT + 2, 1'b1, 32'h0, 1'b1, 1'b0);
      access(1'b1, 1'b0, 32'h40, 32'h0, SZ_W, -1, -1, 32'hFFFFFFFF);

      // Half store with ready delayed; request must hold for three cycles
      expect_txn("sh_slow", 1'b1, 32'h0, 4'b1100, 32'hBEEF0000, 3, 4, 1'b0, 32'h0, 1'b0, 1'b0);
      access(1'b0, 1'b1, 32'h02, 32'h0000BEEF, SZ_H, 3, -1, 32'h0);

      // Byte load with ready and rvalid in the same REQ cycle
      expect_txn("lb_same", 1'b0, 32'h44, 4'b0010, 32'h0, 1, 2, 1'b1, 32'h00CAFEF0, 1'b0, 1'b0);
      access(1'b1, 1'b0, 32'h45, 32'h0, SZ_B, 1, 1, 32'hCAFEF00D);

      // Reset while waiting for read data
      cpu_rd   = 1'b1;
      cpu_wr   = 1'b0;
      cpu_addr = 32'h50;
      cpu_size = SZ_W;
      @(negedge clk);
      check("rst_wait.req_stall", 32'(cpu_stall), 32'd1);
      @(posedge clk);
      #1;
      mem_bus.ready = 1'b1;
      @(negedge clk);
      check("rst_wait.req_valid", 32'(mem_bus.valid), 32'd1);
      @(posedge clk);
      #1;
      mem_bus.ready = 1'b0;
      @(negedge clk);
      check("rst_wait.wait_valid", 32'(mem_bus.valid), 32'd0);
      check("rst_wait.wait_stall", 32'(cpu_stall),     32'd1);
      reset  = 1'b1;
      cpu_rd = 1'b0;
      @(posedge clk);
      #1;
      reset          = 1'b0;
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 32'hFFFFFFFF;
      @(negedge clk);
      check("rst_wait.valid", 32'(mem_bus.valid), 32'd0);
      check("rst_wait.stall", 32'(cpu_stall),     32'd0);
      check("rst_wait.be",    32'(mem_bus.be),    32'd0);
      check("rst_wait.we",    32'(mem_bus.we),    32'd0);
      check("rst_wait.err",   32'(cpu_err),       32'd0);
      check("rst_wait.rdata", cpu_rdata,          32'd0);
      @(posedge clk);
      #1;
      mem_bus.rvalid = 1'b0;
      @(negedge clk);
      check("rst_wait.late_rdata", cpu_rdata,      32'd0);
      check("rst_wait.late_err",   32'(cpu_err),   32'd0);
      check("rst_wait.late_stall", 32'(cpu_stall), 32'd0);
      $display("txn %-9s reset in WAIT, late rvalid ignored", "rst_wait");
      @(posedge clk);
      #1;

      // Normal operation resumes after the abandoned access
      expect_txn("sw_after", 1'b1, 32'h60, 4'b1111, 32'h13579BDF, 1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
      access(1'b0, 1'b1, 32'h60, 32'h13579BDF, SZ_W, 1, -1, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
